vp_cell_scheduler: RTL
======================

Name: vp_cell_scheduler

Overview:
- Sequences one text line of character cells through the bitmap-to-pixels conversion stage of the video pipeline.
- On a line-start pulse it pulls COLUMNS cells from the character fetch stage over a valid/ready handshake.
- It drives the 1-cycle-latency converter and buffers the returned 64-bit pixel words in a small FIFO, which feeds the pixel serializer.
- It manages credit-based backpressure so no converter output is ever lost.

Parameters:
- COLUMNS, 80, cells per text line
- COL_WIDTH, 7, width of column counters; must satisfy 2^COL_WIDTH > COLUMNS
- FIFO_DEPTH, 4, pixel-word FIFO entries; power of two, ≥ 4

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- line_start  in  1  one-cycle pulse: begin a new text line
- fetch_valid  in  1  fetch stage offers a cell
- fetch_ready  out  1  scheduler accepts the cell this cycle
- fetch_foreground  in  4  cell foreground colour index
- fetch_background  in  4  cell background colour index
- fetch_bitmap  in  16  cell glyph row bits
- fetch_blink  in  1  cell blink attribute (used only with VP_BLINK_EN)
- blink_phase  in  1  global blink phase, 1 = hidden (used only with VP_BLINK_EN)
- conv_foreground  out  4  to converter foreground
- conv_background  out  4  to converter background
- conv_bitmap  out  16  to converter bitmap
- conv_enabled  out  1  converter input qualifier
- conv_pixels  in  64  converter output, sixteen 4-bit pixels
- conv_enable  in  1  converter output qualifier, 1 cycle after conv_enabled
- pix_valid  out  1  FIFO head valid
- pix_ready  in  1  consumer pops the head
- pix_data  out  64  FIFO head pixels
- pix_last  out  1  head is the last word of the line
- busy  out  1  state ≠ IDLE
- line_done  out  1  one-cycle pulse when a line fully drains
- line_error  out  1  sticky error flag, cleared by reset only

Behaviour:
- Reset (synchronous, active-high):
  - State to IDLE.
  - Counters, FIFO pointers and the in-flight count cleared.
  - All outputs 0: fetch_ready, conv_*, pix_valid, pix_data, pix_last, busy, line_done, line_error.
  - Reset mid-line abandons the line; any conv_enable in the cycle after reset is ignored.
- State machine:
  - IDLE → RUN on line_start; issued and pushed counters cleared.
  - RUN → DRAIN in the cycle after issued reaches COLUMNS.
  - DRAIN → IDLE when pushed == COLUMNS and the FIFO is empty (last pop done); line_done pulses in that transition cycle.
  - line_start outside IDLE is ignored and sets line_error.
- fetch_ready:
  - Combinational: state == RUN and issued < COLUMNS and (fifo_count + inflight) < FIFO_DEPTH.
  - A pop in the same cycle does not release credit until the next cycle.
- Accept (fetch_valid && fetch_ready):
  - Next cycle: conv_* registered from fetch_*, conv_enabled = 1 for exactly one cycle; otherwise conv_enabled = 0 and conv_* hold.
  - issued += 1 and inflight += 1.
- Push (conv_enable):
  - Writes {last, conv_pixels} into the FIFO; last = (pushed == COLUMNS-1); pushed += 1; inflight -= 1.
  - Simultaneous accept and push leaves inflight unchanged.
  - conv_enable while the FIFO is full, or while IDLE: word dropped, line_error set.
- Pop (pix_valid && pix_ready):
  - Advances the read pointer.
  - Simultaneous push and pop on a full FIFO is legal only because credit prevents fullness.
  - Simultaneous push and pop on an empty FIFO: pushed word appears on pix_* next cycle (no bypass).
- pix_data / pix_last reflect the FIFO head; pix_valid = fifo_count ≠ 0.
- Latency: fetch handshake to pix_valid is 3 cycles when the FIFO is empty.
- Throughput: 1 cell/cycle sustained when pix_ready stays high with FIFO_DEPTH ≥ 4.
- Counters saturate logic-wise at COLUMNS; no wrap within a line.

Optional Feature:
- Macro: VP_BLINK_EN.
- Defined: conv_bitmap = fetch_bitmap & ~{16{fetch_blink & blink_phase}} at register time, so blinking cells render as background during the hidden phase.
- Undefined: fetch_blink and blink_phase are unused and conv_bitmap = fetch_bitmap; all timing is identical.

Decomposition:
- Shared package/include (constant.v): state encodings VPS_IDLE, VPS_RUN, VPS_DRAIN; pixel word width 64; colour index width 4; bitmap width 16.
- One sub-module, vp_pixel_fifo: synchronous FIFO parameterised by width (65) and depth, with count output.
- Scheduler FSM, credit logic and converter drive stay in vp_cell_scheduler.

Test Plan:
- Reset, then line_start with COLUMNS=4, fetch_valid and pix_ready held high, cells bitmap 16'h0001/0002/0004/0008, fg=4'hF, bg=4'h0 → four pix words, first valid 3 cycles after the first accept; pix_last only on the 4th; line_done pulses once; busy falls with it.
- pix_ready low for a full line → fetch_ready drops once fifo_count + inflight = 4; no word lost; releasing pix_ready yields all words in order.
- line_start pulsed during RUN → ignored, line_error = 1 and stays 1 until reset; current line completes normally.
- reset asserted mid-line with 2 words in flight → next cycle all outputs 0, state IDLE; a subsequent line_start produces a clean line.
- fetch_valid toggling 1/0 every cycle with pix_ready random → output order and pix_last position match the input sequence exactly.
- With VP_BLINK_EN: fetch_blink=1, blink_phase=1, bitmap 16'hFFFF, bg=4'h3 → pix_data = 64'h3333_3333_3333_3333; with blink_phase=0 → all pixels equal fg.

Source files
------------

// File: rtl/vp_cell_scheduler_pkg.sv
// Shared definitions for the character-cell scheduler.
// Provides the scheduler state encoding, the pixel/colour/bitmap widths and
// the packed layout of a FIFO entry ({last, pixels}).
package vp_cell_scheduler_pkg;

  localparam int PIX_W    = 64;         // sixteen 4-bit pixels per word
  localparam int COLOR_W  = 4;          // colour index width
  localparam int BITMAP_W = 16;         // glyph row bits per cell
  localparam int WORD_W   = PIX_W + 1;  // FIFO entry: last flag + pixels

  typedef enum logic [1:0] {
    VPS_IDLE  = 2'd0,
    VPS_RUN   = 2'd1,
    VPS_DRAIN = 2'd2
  } vps_state_t;

  typedef struct packed {
    logic             last;
    logic [PIX_W-1:0] pixels;
  } pix_word_t;

endpackage

// File: rtl/vp_pixel_fifo.sv
// Synchronous FIFO holding converted pixel words for the serializer.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push        - write push_data (ignored when full)
//   push_data   - entry to write
//   pop         - advance the read pointer (ignored when empty)
//   head        - entry at the read pointer (no write-to-read bypass)
//   count       - number of stored entries
// DEPTH must be a power of two so the pointers wrap naturally.
module vp_pixel_fifo
  import vp_cell_scheduler_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign wr_en = push && (count != CNT_W'(DEPTH));
  assign rd_en = pop && (count != '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads as zero straight after reset.
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !rd_en) begin
        count <= count + CNT_W'(1);
      end else if (!wr_en && rd_en) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vp_cell_scheduler.sv
// Sequences one text line of character cells through the bitmap-to-pixels
// converter and buffers the converted words for the pixel serializer.
// Optional feature macro: VP_BLINK_EN (blinking cells render as background
// while blink_phase is 1).
//
// Handshakes:
//   fetch_valid/fetch_ready : a cell transfers in any cycle where both are 1.
//   pix_valid/pix_ready     : the FIFO head is consumed in any cycle where
//                             both are 1; pix_data/pix_last hold otherwise.
//   conv_enabled -> conv_enable : converter answers exactly one cycle later
//                             with no stall, so credit is reserved at accept.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   line_start              - pulse: begin a line (only honoured in IDLE)
//   fetch_*                 - cell from the fetch stage
//   blink_phase             - global blink phase (VP_BLINK_EN only)
//   conv_*                  - converter drive / converter result
//   pix_*                   - FIFO head to the serializer
//   busy                    - state is not IDLE
//   line_done               - one-cycle pulse when the line has drained
//   line_error              - sticky: line_start while busy or lost word
module vp_cell_scheduler
  import vp_cell_scheduler_pkg::*;
#(
  parameter int COLUMNS    = 80,
  parameter int COL_WIDTH  = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                line_start,
  input  logic                fetch_valid,
  output logic                fetch_ready,
  input  logic [COLOR_W-1:0]  fetch_foreground,
  input  logic [COLOR_W-1:0]  fetch_background,
  input  logic [BITMAP_W-1:0] fetch_bitmap,
  input  logic                fetch_blink,
  input  logic                blink_phase,
  output logic [COLOR_W-1:0]  conv_foreground,
  output logic [COLOR_W-1:0]  conv_background,
  output logic [BITMAP_W-1:0] conv_bitmap,
  output logic                conv_enabled,
  input  logic [PIX_W-1:0]    conv_pixels,
  input  logic                conv_enable,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [PIX_W-1:0]    pix_data,
  output logic                pix_last,
  output logic                busy,
  output logic                line_done,
  output logic                line_error
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COL_WIDTH-1:0] COLS_L   = COL_WIDTH'(COLUMNS);
  localparam logic [COL_WIDTH-1:0] LAST_COL = COL_WIDTH'(COLUMNS - 1);
  localparam logic [CNT_W:0]       DEPTH_L  = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]     FULL_L   = CNT_W'(FIFO_DEPTH);

  vps_state_t           state;
  logic [COL_WIDTH-1:0] issued;
  logic [COL_WIDTH-1:0] pushed;
  logic [CNT_W-1:0]     inflight;
  logic [CNT_W-1:0]     fifo_count;
  logic [CNT_W:0]       credit_used;
  logic                 after_reset;
  logic                 accept;
  logic                 push_in;
  logic                 push_live;
  logic                 fifo_full;
  logic                 fifo_wr;
  logic                 pop;
  logic [BITMAP_W-1:0]  bitmap_masked;
  pix_word_t            wr_word;
  pix_word_t            head_word;

`ifdef VP_BLINK_EN
  assign bitmap_masked = fetch_bitmap & ~{BITMAP_W{fetch_blink & blink_phase}};
`else
  logic unused_blink;
  assign unused_blink  = fetch_blink ^ blink_phase;
  assign bitmap_masked = fetch_bitmap;
`endif

  // Words already in the FIFO plus words still inside the converter must
  // never exceed the FIFO size, so every converter result has a slot.
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign fetch_ready = (state == VPS_RUN) && (issued < COLS_L) &&
                       (credit_used < DEPTH_L);
  assign accept      = fetch_valid && fetch_ready;

  // A converter result in the first cycle after reset belongs to the
  // abandoned line and is discarded silently.
  assign push_in   = conv_enable && !after_reset;
  assign push_live = push_in && (state != VPS_IDLE);
  assign fifo_full = (fifo_count == FULL_L);
  assign fifo_wr   = push_live && !fifo_full;
  assign pop       = pix_valid && pix_ready;

  assign wr_word   = '{last: (pushed == LAST_COL), pixels: conv_pixels};
  assign pix_valid = (fifo_count != '0);
  assign pix_data  = head_word.pixels;
  assign pix_last  = head_word.last;
  assign busy      = (state != VPS_IDLE);

  vp_pixel_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_wr),
    .push_data (wr_word),
    .pop       (pop),
    .head      (head_word),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= VPS_IDLE;
      issued          <= '0;
      pushed          <= '0;
      inflight        <= '0;
      after_reset     <= 1'b1;
      conv_foreground <= '0;
      conv_background <= '0;
      conv_bitmap     <= '0;
      conv_enabled    <= 1'b0;
      line_done       <= 1'b0;
      line_error      <= 1'b0;
    end else begin
      after_reset  <= 1'b0;
      line_done    <= 1'b0;
      conv_enabled <= accept;

      if (accept) begin
        conv_foreground <= fetch_foreground;
        conv_background <= fetch_background;
        conv_bitmap     <= bitmap_masked;
      end

      // Accept and push in the same cycle cancel out.
      if (accept && !push_live) begin
        inflight <= inflight + CNT_W'(1);
      end else if (!accept && push_live && (inflight != '0)) begin
        inflight <= inflight - CNT_W'(1);
      end

      if (accept && (issued < COLS_L)) begin
        issued <= issued + COL_WIDTH'(1);
      end
      // A dropped word still counts, so the line can finish and report.
      if (push_live && (pushed < COLS_L)) begin
        pushed <= pushed + COL_WIDTH'(1);
      end

      if ((line_start && (state != VPS_IDLE)) ||
          (push_in && ((state == VPS_IDLE) || fifo_full))) begin
        line_error <= 1'b1;
      end

      case (state)
        VPS_IDLE: begin
          if (line_start) begin
            state  <= VPS_RUN;
            issued <= '0;
            pushed <= '0;
          end
        end
        VPS_RUN: begin
          if (issued == COLS_L) begin
            state <= VPS_DRAIN;
          end
        end
        VPS_DRAIN: begin
          if ((pushed == COLS_L) && (fifo_count == '0)) begin
            state     <= VPS_IDLE;
            line_done <= 1'b1;
          end
        end
        default: state <= VPS_IDLE;
      endcase
    end
  end

endmodule
